// File: rtl/move_cmd_exec.sv
// Board move executor: latches a command word, steps position one square per SQ_CYCLES, optional fanfare, then responds.
// Latency: ack at T+1, send_resp at T+2+n*SQ_CYCLES (+FAN_CYCLES with fanfare); illegal opcode responds at T+2.
// Backpressure: one command at a time, cmd_rdy ignored outside IDLE; define MOVE_EXEC_BOUNDS_EN for a 5x5 bounded board.
module move_cmd_exec #(
    parameter int SQ_CYCLES  = 8,
    parameter int FAN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        busy,
    output logic [2:0]  xx,
    output logic [2:0]  yy,
    output logic        fanfare,
    output logic        err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACK     = 3'd1;
    localparam logic [2:0] MOVE    = 3'd2;
    localparam logic [2:0] FANFARE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [9:0] SQ_LAST  = 10'(SQ_CYCLES - 1);
    localparam logic [9:0] FAN_LAST = 10'(FAN_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] op_q;
    logic       fan_q;
    logic [7:0] hdg_q;
    logic [3:0] rem;
    logic [9:0] cnt;

    logic       hdg_ok;
    logic [2:0] nx;
    logic [2:0] ny;
    logic [2:0] after_move;

    assign clr_cmd_rdy = (state == ACK);
    assign send_resp   = (state == RESP);
    assign busy        = (state != IDLE);
    assign fanfare     = (state == FANFARE);
    assign after_move  = fan_q ? FANFARE : RESP;

    // Next position for one square in the latched heading; 3-bit arithmetic wraps modulo 8.
    always_comb begin
        hdg_ok = 1'b1;
        nx     = xx;
        ny     = yy;
        case (hdg_q)
            8'h00:   ny = yy + 3'd1;
            8'h7F:   ny = yy - 3'd1;
            8'h3F:   nx = xx - 3'd1;
            8'hBF:   nx = xx + 3'd1;
            default: hdg_ok = 1'b0;
        endcase
    end

`ifdef MOVE_EXEC_BOUNDS_EN
    logic oob;

    always_comb begin
        case (hdg_q)
            8'h00:   oob = (yy >= 3'd4);
            8'h7F:   oob = (yy == 3'd0);
            8'h3F:   oob = (xx == 3'd0);
            8'hBF:   oob = (xx >= 3'd4);
            default: oob = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 3'd0;
            fan_q <= 1'b0;
            hdg_q <= 8'd0;
            rem   <= 4'd0;
            cnt   <= 10'd0;
            xx    <= 3'd2;
            yy    <= 3'd2;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        op_q  <= cmd[15:13];
                        fan_q <= cmd[12];
                        hdg_q <= cmd[11:4];
                        rem   <= cmd[3:0];
                        cnt   <= 10'd0;
                        state <= ACK;
                    end
                end
                ACK: begin
                    cnt <= 10'd0;
                    if (op_q != OP_MOVE) begin
                        err   <= 1'b1;
                        state <= RESP;
                    end else if (!hdg_ok) begin
                        err   <= 1'b1;
                        state <= after_move;
                    end else begin
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (rem == 4'd0) begin
                        cnt   <= 10'd0;
                        state <= after_move;
                    end else if (cnt == SQ_LAST) begin
                        cnt <= 10'd0;
                        rem <= rem - 4'd1;
`ifdef MOVE_EXEC_BOUNDS_EN
                        // Off-board step keeps position but still consumes the square's time.
                        if (oob) begin
                            err <= 1'b1;
                        end else begin
                            xx <= nx;
                            yy <= ny;
                        end
`else
                        xx <= nx;
                        yy <= ny;
`endif
                        if (rem == 4'd1) begin
                            state <= after_move;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                FANFARE: begin
                    if (cnt == FAN_LAST) begin
                        cnt   <= 10'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_cmd_exec.sv
// Directed bench for move_cmd_exec: latency, position, fanfare, error, back-to-back and reset-abort checks.
module tb_move_cmd_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        busy;
    logic [2:0]  xx;
    logic [2:0]  yy;
    logic        fanfare;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    move_cmd_exec #(.SQ_CYCLES(8), .FAN_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .busy        (busy),
        .xx          (xx),
        .yy          (yy),
        .fanfare     (fanfare),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        cmd_rdy = 1'b0;
        cmd     = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive a command for one cycle (T), leaving the bench in cycle T+1 with cmd scrambled.
    task automatic send(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        cmd     = 16'hFFFF;
    endtask

    task automatic wait_resp(input int start, input int maxc, output int lat, output int fan_n);
        int t;
        t     = start;
        fan_n = 0;
        while (send_resp !== 1'b1 && t < maxc) begin
            if (fanfare === 1'b1) fan_n++;
            tick();
            t++;
        end
        lat = t;
    endtask

    initial begin
        int lat;
        int fan_n;
        int resp_n;
        logic [31:0] clr_mask;
        logic [31:0] resp_mask;

        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xx", 32'(xx), 32'd2);
        chk("rst_yy", 32'(yy), 32'd2);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
        chk("rst_resp", 32'(send_resp), 32'd0);
        chk("rst_fan", 32'(fanfare), 32'd0);

        // North 2 squares
        send(16'h4002);
        chk("n2_clr_t1", 32'(clr_cmd_rdy), 32'd1);
        chk("n2_busy", 32'(busy), 32'd1);
        repeat (8) tick();
        chk("n2_yy_t9", 32'(yy), 32'd2);
        tick();
        chk("n2_yy_t10", 32'(yy), 32'd3);
        chk("n2_clr_t10", 32'(clr_cmd_rdy), 32'd0);
        wait_resp(10, 60, lat, fan_n);
        chk("n2_lat", 32'(lat), 32'd18);
        chk("n2_yy", 32'(yy), 32'd4);
        chk("n2_xx", 32'(xx), 32'd2);
        chk("n2_err", 32'(err), 32'd0);
        chk("n2_fan", 32'(fan_n), 32'd0);
        tick();
        chk("n2_resp_pulse", 32'(send_resp), 32'd0);
        chk("n2_idle", 32'(busy), 32'd0);

        // East 1 square with fanfare
        do_reset();
        send(16'h5BF1);
        wait_resp(1, 60, lat, fan_n);
        chk("fan_lat", 32'(lat), 32'd14);
        chk("fan_cycles", 32'(fan_n), 32'd4);
        chk("fan_xx", 32'(xx), 32'd3);
        chk("fan_yy", 32'(yy), 32'd2);
        tick();

        // Illegal opcode
        send(16'h2000);
        chk("ill_clr", 32'(clr_cmd_rdy), 32'd1);
        tick();
        chk("ill_resp_t2", 32'(send_resp), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_xx", 32'(xx), 32'd3);
        chk("ill_yy", 32'(yy), 32'd2);
        tick();

        // Edge of board: reach (4,4) then go north 2
        do_reset();
        send(16'h4BF2);
        wait_resp(1, 60, lat, fan_n);
        tick();
        send(16'h4002);
        wait_resp(1, 60, lat, fan_n);
        chk("edge_xx", 32'(xx), 32'd4);
        chk("edge_yy0", 32'(yy), 32'd4);
        tick();
        send(16'h4002);
        wait_resp(1, 60, lat, fan_n);
        chk("edge_lat", 32'(lat), 32'd18);
`ifdef MOVE_EXEC_BOUNDS_EN
        chk("edge_yy", 32'(yy), 32'd4);
        chk("edge_err", 32'(err), 32'd1);
`else
        chk("edge_yy", 32'(yy), 32'd6);
        chk("edge_err", 32'(err), 32'd0);
`endif
        tick();

        // Back-to-back zero-square moves with cmd_rdy held high
        do_reset();
        cmd       = 16'h4000;
        cmd_rdy   = 1'b1;
        clr_mask  = 32'd0;
        resp_mask = 32'd0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            clr_mask[k]  = clr_cmd_rdy;
            resp_mask[k] = send_resp;
        end
        cmd_rdy = 1'b0;
        chk("b2b_clr_mask", clr_mask, 32'h0000_2222);
        chk("b2b_resp_mask", resp_mask, 32'h0000_8888);
        tick();
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset mid-move
        do_reset();
        send(16'h47F3);
        repeat (11) tick();
        chk("abort_yy_mid", 32'(yy), 32'd1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        resp_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (send_resp === 1'b1) resp_n++;
            tick();
        end
        chk("abort_no_resp", 32'(resp_n), 32'd0);
        chk("abort_xx", 32'(xx), 32'd2);
        chk("abort_yy", 32'(yy), 32'd2);
        chk("abort_idle", 32'(busy), 32'd0);
        send(16'h4000);
        chk("abort_next_clr", 32'(clr_cmd_rdy), 32'd1);
        wait_resp(1, 60, lat, fan_n);
        chk("abort_next_lat", 32'(lat), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/move_cmd_exec.md
MOVE_CMD_EXEC -- requirements
Module: move_cmd_exec

Interface
REQ-001 Parameter SQ_CYCLES, default 8: clock cycles spent executing one square of travel (legal range 1..1023).
REQ-002 Parameter FAN_CYCLES, default 4: clock cycles spent in fanfare after a move with cmd[12]=1 (legal range 1..1023).
REQ-003 clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd  input  16  command word: [15:13] opcode, [12] fanfare, [11:4] heading, [3:0] squares.
REQ-006 cmd_rdy  input  1  command valid from the command source.
REQ-007 clr_cmd_rdy  output  1  one-cycle acknowledge; the command has been latched.
REQ-008 send_resp  output  1  one-cycle pulse; the command has completed.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 xx, yy  output  3 each  current board position.
REQ-011 fanfare  output  1  high throughout the FANFARE state.
REQ-012 err  output  1  sticky error flag; cleared only by reset.

Function
REQ-013 States SHALL be IDLE, ACK, MOVE, FANFARE and RESP, with state register width 3.
REQ-014 In IDLE with cmd_rdy=1 at cycle T, the block SHALL latch cmd and enter ACK at T+1; clr_cmd_rdy is high only during T+1.
REQ-015 cmd_rdy SHALL be ignored in every state except IDLE; no queuing.
REQ-016 From ACK the block SHALL go to MOVE if opcode=3'b010, and to RESP otherwise, setting err for an illegal opcode.
REQ-017 Heading decode: 8'h00 is y+1, 8'h7F is y-1, 8'h3F is x-1, 8'hBF is x+1; any other heading SHALL set err and skip MOVE, going to RESP, or to FANFARE if the fanfare bit is set.
REQ-018 MOVE SHALL run a 10-bit cycle counter; each SQ_CYCLES cycles completes one square, updating position once and decrementing the 4-bit remaining-square count.
REQ-019 squares=0 SHALL leave MOVE after one cycle with no position change.
REQ-020 When remaining squares reach 0, the block SHALL go to FANFARE if the latched cmd[12]=1, else to RESP.
REQ-021 FANFARE SHALL last exactly FAN_CYCLES cycles, then go to RESP.
REQ-022 RESP SHALL last one cycle with send_resp=1, then return to IDLE.
REQ-023 Latency: for a legal move of n>=1 squares accepted at T, send_resp SHALL be asserted at T+2+n*SQ_CYCLES, plus FAN_CYCLES when the fanfare bit is set.
REQ-024 cmd changes after acceptance SHALL NOT affect the command in progress.
REQ-025 If cmd_rdy is high in the RESP cycle, that command SHALL NOT be accepted until the next IDLE cycle.

Reset
REQ-026 With rst=1 at a clock edge: state IDLE, xx=2, yy=2, err=0, counters 0, and clr_cmd_rdy, send_resp, busy and fanfare all 0.
REQ-027 Reset during MOVE or FANFARE SHALL abort the command with no send_resp and no further position change.

Configuration
REQ-028 Macro MOVE_EXEC_BOUNDS_EN defined: board is 5x5 (0..4); a square step leaving the board SHALL leave position unchanged and set err, with execution timing unchanged.
REQ-029 MOVE_EXEC_BOUNDS_EN undefined: no bounds check; xx and yy wrap modulo 8, and out-of-board steps SHALL NOT set err.

Verification
REQ-030 Reset, then cmd=16'h4002 (north, 2 squares) with cmd_rdy at T -> clr_cmd_rdy at T+1, yy=3 at T+10, yy=4 at T+18, send_resp at T+18, xx=2, err=0.
REQ-031 cmd=16'h5BF1 (fanfare, east, 1 square) from (2,2) -> xx=3, fanfare high for 4 cycles, send_resp at T+14.
REQ-032 cmd=16'h2000 (illegal opcode) -> clr_cmd_rdy at T+1, send_resp at T+2, err=1, position unchanged.
REQ-033 From (4,4) send cmd=16'h4002, with and without MOVE_EXEC_BOUNDS_EN -> defined: yy=4 and err=1; undefined: yy=6 and err=0; send_resp at T+18 in both cases.
REQ-034 Hold cmd_rdy=1 continuously with cmd=16'h4000 -> back-to-back accepts every 4 cycles, each giving exactly one clr_cmd_rdy and one send_resp.
REQ-035 Assert rst mid-MOVE of cmd=16'h47F3 -> no send_resp, position (2,2), state IDLE; the next command is accepted normally.
